// File: rtl/sharpmz_pkg.sv
// Shared types and MZF tape header layout
// for the Sharp MZ ioctl loader.
package sharpmz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } mzf_state_e;

  localparam int MZF_HDR_LEN = 128;

  localparam int HDR_ATTR = 0;
  localparam int HDR_SIZE = 18;
  localparam int HDR_LOAD = 20;
  localparam int HDR_EXEC = 22;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } mzf_wr_t;

endpackage

// File: rtl/mzf_wr_fifo.sv
// First-word-fall-through write FIFO holding
// {address, data} pairs bound for emulator RAM.
module mzf_wr_fifo
  import sharpmz_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  mzf_wr_t                data_i,
  output mzf_wr_t                data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  mzf_wr_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // a full FIFO still accepts a push when
  // the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ioctl_mzf_loader.sv
// Parses an MZF tape image from the HPS ioctl
// stream and writes its body into emulator RAM.
module ioctl_mzf_loader
  import sharpmz_pkg::*;
#(
  parameter logic [7:0] MZF_INDEX  = 8'h01,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic [7:0]  hdr_attr,
  output logic [15:0] hdr_size,
  output logic [15:0] hdr_load,
  output logic [15:0] hdr_exec,
  output logic        load_done,
  output logic        load_err,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mzf_state_e  state_q, state_d;
  logic        dl_q;
  logic [7:0]  attr_q, attr_d;
  logic [15:0] size_q, size_d;
  logic [15:0] load_q, load_d;
  logic [15:0] exec_q, exec_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        wr_acc;
  logic        start;
  logic        dl_fall;
  logic        hdr_last;
  logic        hdr_bad;
  logic        in_range;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        flush;
  logic        full;
  logic        empty;
  logic [24:0] offset;
  logic [CW-1:0] count;
  mzf_wr_t     wr_ent;
  mzf_wr_t     head;

  assign wr_acc  = ioctl_wr & ~ioctl_wait;
  assign dl_fall = ~ioctl_download & dl_q;
  assign start   = ioctl_download & ~dl_q
                 & (ioctl_index == MZF_INDEX);

  assign offset   = ioctl_addr - 25'(MZF_HDR_LEN);
  assign in_range = (ioctl_addr >= 25'(MZF_HDR_LEN))
                  && (offset < {9'd0, size_q});
  assign hdr_last = wr_acc
                  && (ioctl_addr == 25'(MZF_HDR_LEN - 1));
  // 17-bit sum so an image ending exactly at 64K is legal
  assign hdr_bad  = (size_q == '0)
                  || (({1'b0, load_q} + {1'b0, size_q})
                      > 17'h10000);

  assign push_req = (state_q == ST_DATA) && wr_acc && in_range;
  assign pop      = mem_req & mem_ack;
  assign push     = push_req & (~full | pop);
  assign flush    = (state_q == ST_IDLE && start)
                  || (state_q == ST_ERROR);
  assign wr_ent   = {load_q + offset[15:0], ioctl_dout};

  assign ioctl_wait = (count >= CW'(FIFO_DEPTH - 1));
  assign mem_req    = ~empty
                    & ((state_q == ST_DATA)
                    || (state_q == ST_DRAIN));
  assign mem_addr   = head.addr;
  assign mem_data   = head.data;

  assign hdr_attr  = attr_q;
  assign hdr_size  = size_q;
  assign hdr_load  = load_q;
  assign hdr_exec  = exec_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign busy      = (state_q != ST_IDLE);

  mzf_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_ent),
    .data_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  always_comb begin
    attr_d = attr_q;
    size_d = size_q;
    load_d = load_q;
    exec_d = exec_q;
    if (state_q == ST_HEADER && wr_acc) begin
      case (ioctl_addr)
        25'(HDR_ATTR):     attr_d        = ioctl_dout;
        25'(HDR_SIZE):     size_d[7:0]   = ioctl_dout;
        25'(HDR_SIZE + 1): size_d[15:8]  = ioctl_dout;
        25'(HDR_LOAD):     load_d[7:0]   = ioctl_dout;
        25'(HDR_LOAD + 1): load_d[15:8]  = ioctl_dout;
        25'(HDR_EXEC):     exec_d[7:0]   = ioctl_dout;
        25'(HDR_EXEC + 1): exec_d[15:8]  = ioctl_dout;
        default:           attr_d        = attr_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HEADER;
          pcnt_d  = '0;
          wcnt_d  = '0;
        end
      end
      ST_HEADER: begin
        if (dl_fall)
          state_d = ST_DRAIN;
        else if (hdr_last)
          state_d = hdr_bad ? ST_ERROR : ST_DATA;
      end
      ST_DATA: begin
        if (push) pcnt_d = pcnt_q + 16'd1;
        if (pop)  wcnt_d = wcnt_q + 16'd1;
        if (pop && wcnt_d == size_q)
          state_d = ST_DONE;
        else if (push_req && !push)
          state_d = ST_ERROR;
        else if (dl_fall && pcnt_q < size_q)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (empty) state_d = ST_ERROR;
      end
      ST_DONE: begin
        if (!ioctl_download) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (!ioctl_download) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && start) err_d = 1'b0;
    if (state_d == ST_ERROR)         err_d = 1'b1;
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // dl_q resets high so a download already in
  // flight at reset release is not seen as a start
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dl_q    <= 1'b1;
      attr_q  <= '0;
      size_q  <= '0;
      load_q  <= '0;
      exec_q  <= '0;
      pcnt_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      attr_q  <= attr_d;
      size_q  <= size_d;
      load_q  <= load_d;
      exec_q  <= exec_d;
      pcnt_q  <= pcnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ioctl_mzf_loader.sv
// Bench for ioctl_mzf_loader: vector table of whole
// images plus back-pressure and reset sequences.
module tb_ioctl_mzf_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        mem_ack = 1'b1;
  logic        ioctl_wait;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  hdr_attr;
  logic [15:0] hdr_size, hdr_load, hdr_exec;
  logic        load_done, load_err, busy;

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  int busy_cnt = 0;
  int sent = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] sz;
    logic [15:0] ld;
    logic [15:0] ex;
    int          nsend;
    int          exp_wr;
    bit          exp_done;
    bit          exp_err;
    bit          exp_hdr_err;
    bit          exp_busy;
  } vec_t;

  ioctl_mzf_loader #(
    .MZF_INDEX  (8'h01),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_ack        (mem_ack),
    .hdr_attr       (hdr_attr),
    .hdr_size       (hdr_size),
    .hdr_load       (hdr_load),
    .hdr_exec       (hdr_exec),
    .load_done      (load_done),
    .load_err       (load_err),
    .busy           (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h",
                  name, act, exp);
  endtask

  // scoreboard: sampled 1 time unit before each rising edge
  always begin
    logic [23:0] e;
    @(negedge clk_sys);
    #4;
    if (reset_n) begin
      if (mem_req && mem_ack) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_extra: got write %h@%h, required none",
                   mem_data, mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_write", {8'h0, mem_addr, mem_data}, {8'h0, e});
        end
      end
      if (mem_req)   req_cnt++;
      if (load_done) done_cnt++;
      if (busy)      busy_cnt++;
    end
  end

  function automatic logic [7:0] hdr_byte(input int a,
      input logic [15:0] sz, input logic [15:0] ld,
      input logic [15:0] ex);
    case (a)
      0:  return 8'h01;
      18: return sz[7:0];
      19: return sz[15:8];
      20: return ld[7:0];
      21: return ld[15:8];
      22: return ex[7:0];
      23: return ex[15:8];
      default: return 8'(a) ^ 8'h5A;
    endcase
  endfunction

  function automatic bit hdr_ok(input logic [7:0] idx,
      input logic [15:0] sz, input logic [15:0] ld);
    return (idx == 8'h01) && (sz != 16'h0)
        && (({1'b0, ld} + {1'b0, sz}) <= 17'h10000);
  endfunction

  task automatic wr_byte(input logic [24:0] a,
                         input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 1000) begin
      n_chk++;
      $display("FAIL wait_timeout: ioctl_wait %0b, required 0",
               ioctl_wait);
      return;
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] idx,
      input logic [15:0] sz, input logic [15:0] ld,
      input logic [15:0] ex);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int a = 0; a < 128; a++)
      wr_byte(25'(a), hdr_byte(a, sz, ld, ex));
  endtask

  task automatic send_data(input logic [15:0] sz,
      input logic [15:0] ld, input int n, input int first,
      input bit ok);
    for (int i = first; i < first + n; i++) begin
      logic [7:0] d;
      d = 8'hAA + 8'(i * 17);
      if (ok && i < int'(sz))
        exp_q.push_back({ld + 16'(i), d});
      wr_byte(25'(128 + i), d);
      sent++;
    end
  endtask

  task automatic end_load();
    repeat (8) @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic clr_counts();
    wr_cnt   = 0;
    done_cnt = 0;
    req_cnt  = 0;
    busy_cnt = 0;
  endtask

  initial begin
    vec_t vt[7];
    bit   ok;
    vt[0] = '{8'h01, 16'h0004, 16'h1200, 16'h1200, 4,  4, 1, 0, 0, 1};
    vt[1] = '{8'h02, 16'h0004, 16'h1200, 16'h1200, 4,  0, 0, 0, 0, 0};
    vt[2] = '{8'h01, 16'h0003, 16'h4000, 16'h4123, 6,  3, 1, 0, 0, 1};
    vt[3] = '{8'h01, 16'h0004, 16'hFFFC, 16'h0000, 4,  4, 1, 0, 0, 1};
    vt[4] = '{8'h01, 16'h0020, 16'hFFF0, 16'h0000, 32, 0, 0, 1, 1, 1};
    vt[5] = '{8'h01, 16'h0000, 16'h1000, 16'h1000, 2,  0, 0, 1, 1, 1};
    vt[6] = '{8'h01, 16'h0008, 16'h3000, 16'h3000, 5,  5, 0, 1, 0, 1};

    repeat (2) @(negedge clk_sys);
    chk("rst_ctrl", {mem_req, ioctl_wait, load_done,
                     load_err, busy}, 0);
    chk("rst_hdr_as", {hdr_attr, hdr_size}, 0);
    chk("rst_hdr_le", {hdr_load, hdr_exec}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    foreach (vt[k]) begin
      clr_counts();
      ok = hdr_ok(vt[k].idx, vt[k].sz, vt[k].ld);
      send_header(vt[k].idx, vt[k].sz, vt[k].ld, vt[k].ex);
      chk($sformatf("v%0d_hdr_err", k), load_err,
          vt[k].exp_hdr_err);
      send_data(vt[k].sz, vt[k].ld, vt[k].nsend, 0, ok);
      end_load();
      chk($sformatf("v%0d_writes", k), wr_cnt, vt[k].exp_wr);
      chk($sformatf("v%0d_done", k), done_cnt, vt[k].exp_done);
      chk($sformatf("v%0d_err", k), load_err, vt[k].exp_err);
      chk($sformatf("v%0d_idle", k), busy, 0);
      chk($sformatf("v%0d_busy", k), busy_cnt != 0,
          vt[k].exp_busy);
      chk($sformatf("v%0d_left", k), exp_q.size(), 0);
      if (vt[k].exp_wr == 0)
        chk($sformatf("v%0d_noreq", k), req_cnt, 0);
      if (vt[k].exp_busy) begin
        chk($sformatf("v%0d_attr", k), hdr_attr, 8'h01);
        chk($sformatf("v%0d_size", k), hdr_size, vt[k].sz);
        chk($sformatf("v%0d_load", k), hdr_load, vt[k].ld);
        chk($sformatf("v%0d_exec", k), hdr_exec, vt[k].ex);
      end
      exp_q.delete();
    end

    // back-pressure: RAM stalls for 20 cycles
    clr_counts();
    send_header(8'h01, 16'd16, 16'h2000, 16'h2000);
    mem_ack = 1'b0;
    sent    = 0;
    fork
      send_data(16'd16, 16'h2000, 16, 0, 1'b1);
      begin
        repeat (20) @(negedge clk_sys);
        chk("bp_wait", ioctl_wait, 1);
        chk("bp_sent", sent, 3);
        chk("bp_held", wr_cnt, 0);
        mem_ack = 1'b1;
      end
    join
    end_load();
    chk("bp_writes", wr_cnt, 16);
    chk("bp_done", done_cnt, 1);
    chk("bp_err", load_err, 0);
    chk("bp_left", exp_q.size(), 0);
    exp_q.delete();

    // reset pulse in the middle of the data phase
    clr_counts();
    send_header(8'h01, 16'd8, 16'h5000, 16'h5000);
    mem_ack = 1'b0;
    send_data(16'd8, 16'h5000, 2, 0, 1'b1);
    @(negedge clk_sys);
    chk("rm_pre_req", mem_req, 1);
    chk("rm_pre_wr", wr_cnt, 0);
    reset_n = 1'b0;
    #2;
    chk("rm_ctrl", {mem_req, ioctl_wait, load_done,
                    load_err, busy}, 0);
    chk("rm_hdr_as", {hdr_attr, hdr_size}, 0);
    chk("rm_hdr_le", {hdr_load, hdr_exec}, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    exp_q.delete();
    mem_ack = 1'b1;
    clr_counts();
    send_data(16'd8, 16'h5000, 6, 2, 1'b0);
    repeat (4) @(negedge clk_sys);
    chk("rm_nowrite", wr_cnt, 0);
    chk("rm_noreq", req_cnt, 0);
    chk("rm_idle", busy_cnt, 0);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    clr_counts();
    send_header(8'h01, 16'd2, 16'h6000, 16'h6000);
    send_data(16'd2, 16'h6000, 2, 0, 1'b1);
    end_load();
    chk("rm_next_wr", wr_cnt, 2);
    chk("rm_next_done", done_cnt, 1);
    chk("rm_next_err", load_err, 0);
    chk("rm_next_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
